// File: rtl/rle_decoder.sv
// Run-length decoder: reads {byte,count} pairs (two per 32-bit word) from a single-port
// DPSRAM and writes the expanded byte stream back, packed four bytes per little-endian word.
module rle_decoder #(
   parameter int ADDR_W  = 16,
   parameter int COUNT_W = 8
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              start,
   input  logic [31:0]       rle_addr,
   input  logic [31:0]       rle_size,
   input  logic [31:0]       out_addr,
   output logic [31:0]       out_size,
   output logic              done,
   output logic              port_A_clk,
   output logic [ADDR_W-1:0] port_A_addr,
   output logic [31:0]       port_A_data_in,
   input  logic [31:0]       port_A_data_out,
   output logic              port_A_we
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      EXPAND  = 3'd3,
      WRITE   = 3'd4,
      FLUSH   = 3'd5,
      FIN     = 3'd6
   } state_t;

   state_t             state_r;
   logic [ADDR_W-1:0]  rd_ptr_r;
   logic [ADDR_W-1:0]  wr_ptr_r;
   logic [29:0]        words_left_r;
   logic [31:0]        word_r;
   logic               half_r;
   logic [COUNT_W-1:0] rem_r;
   logic [1:0]         lane_r;
   logic [31:0]        pack_r;
   logic [7:0]         cur_byte_s;
   logic [31:0]        pack_next_s;
   logic               unused_s;

   // Places byte b into lane l of packed word p (lane 0 is the least significant byte).
   function automatic logic [31:0] put_byte(input logic [31:0] p, input logic [1:0] l,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = p;
      case (l)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         2'd3:    r[31:24] = b;
         default: r        = p;
      endcase
      return r;
   endfunction

   assign port_A_clk = clk;
   assign unused_s   = ^{1'b0, rle_addr[31:ADDR_W], out_addr[31:ADDR_W], rle_size[1:0], word_r[7:0]};

   // Byte of the pair currently being expanded, and the pack word once it is inserted.
   always_comb begin
      cur_byte_s = 8'd0;
      if (half_r) begin
         cur_byte_s = word_r[31:24];
      end else begin
         cur_byte_s = word_r[15:8];
      end
      pack_next_s = put_byte(pack_r, lane_r, cur_byte_s);
   end

   // Decoder FSM; memory-port outputs are set when entering the state that uses them.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r        <= IDLE;
         rd_ptr_r       <= '0;
         wr_ptr_r       <= '0;
         words_left_r   <= 30'd0;
         word_r         <= 32'd0;
         half_r         <= 1'b0;
         rem_r          <= '0;
         lane_r         <= 2'd0;
         pack_r         <= 32'd0;
         out_size       <= 32'd0;
         done           <= 1'b0;
         port_A_addr    <= '0;
         port_A_data_in <= 32'd0;
         port_A_we      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               port_A_we <= 1'b0;
               if (start) begin
                  rd_ptr_r     <= rle_addr[ADDR_W-1:0];
                  wr_ptr_r     <= out_addr[ADDR_W-1:0];
                  words_left_r <= rle_size[31:2];
                  out_size     <= 32'd0;
                  lane_r       <= 2'd0;
                  pack_r       <= 32'd0;
                  done         <= 1'b0;
                  port_A_addr  <= rle_addr[ADDR_W-1:0];
                  if (rle_size == 32'd0) begin
                     state_r <= FIN;
                  end else begin
                     state_r <= RD_REQ;
                  end
               end
            end
            RD_REQ: begin
               port_A_we <= 1'b0;
               state_r   <= RD_WAIT;
            end
            RD_WAIT: begin
               word_r       <= port_A_data_out;
               rd_ptr_r     <= rd_ptr_r + ADDR_W'(4);
               words_left_r <= words_left_r - 30'd1;
               half_r       <= 1'b0;
               rem_r        <= port_A_data_out[COUNT_W-1:0];
               state_r      <= EXPAND;
            end
            EXPAND: begin
               if (rem_r != '0) begin
                  pack_r   <= pack_next_s;
                  rem_r    <= rem_r - COUNT_W'(1);
                  lane_r   <= lane_r + 2'd1;
                  out_size <= out_size + 32'd1;
                  if (lane_r == 2'd3) begin
                     port_A_we      <= 1'b1;
                     port_A_addr    <= wr_ptr_r;
                     port_A_data_in <= pack_next_s;
                     state_r        <= WRITE;
                  end
               end else if (!half_r) begin
                  half_r <= 1'b1;
                  rem_r  <= word_r[16 +: COUNT_W];
               end else if (words_left_r != 30'd0) begin
                  port_A_addr <= rd_ptr_r;
                  state_r     <= RD_REQ;
               end else begin
                  // A partial pack is written zero-padded; an empty one needs no write.
                  port_A_addr <= wr_ptr_r;
                  state_r     <= FLUSH;
                  if (lane_r != 2'd0) begin
                     port_A_we      <= 1'b1;
                     port_A_data_in <= pack_r;
                  end
               end
            end
            WRITE: begin
               port_A_we   <= 1'b0;
               port_A_addr <= rd_ptr_r;
               wr_ptr_r    <= wr_ptr_r + ADDR_W'(4);
               pack_r      <= 32'd0;
               lane_r      <= 2'd0;
               state_r     <= EXPAND;
            end
            FLUSH: begin
               port_A_we   <= 1'b0;
               port_A_addr <= rd_ptr_r;
               state_r     <= FIN;
            end
            FIN: begin
               port_A_we <= 1'b0;
               done      <= 1'b1;
               state_r   <= IDLE;
            end
            default: begin
               port_A_we <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: directed frames plus random frames, checked
// against a byte-stream reference model built from the pair format.
module tb_rle_decoder;

   logic        clk = 1'b0;
   logic        nreset;
   logic        start;
   logic [31:0] rle_addr;
   logic [31:0] rle_size;
   logic [31:0] out_addr;
   logic [31:0] out_size;
   logic        done;
   logic        port_A_clk;
   logic [15:0] port_A_addr;
   logic [31:0] port_A_data_in;
   logic [31:0] port_A_data_out;
   logic        port_A_we;

   logic [31:0] mem [0:16383];
   logic [31:0] frame [$];
   logic [31:0] wl_addr [$];
   logic [31:0] wl_data [$];
   logic [31:0] exp_addr [$];
   logic [31:0] exp_data [$];
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   rle_decoder #(.ADDR_W(16), .COUNT_W(8)) dut (
      .clk(clk), .nreset(nreset), .start(start), .rle_addr(rle_addr), .rle_size(rle_size),
      .out_addr(out_addr), .out_size(out_size), .done(done), .port_A_clk(port_A_clk),
      .port_A_addr(port_A_addr), .port_A_data_in(port_A_data_in),
      .port_A_data_out(port_A_data_out), .port_A_we(port_A_we)
   );

   // Synchronous-read memory; writes are only logged so the input frame is never disturbed.
   always @(posedge clk) begin
      port_A_data_out <= mem[port_A_addr[15:2]];
      if (port_A_we === 1'b1) begin
         wl_addr.push_back({16'h0000, port_A_addr});
         wl_data.push_back(port_A_data_in);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_frame(input logic [31:0] base);
      for (int i = 0; i < frame.size(); i++) mem[(base[15:2] + i) % 16384] = frame[i];
   endtask

   // Expands the frame to a byte list, then groups it into zero-padded little-endian words.
   task automatic build_expect(input logic [31:0] oa, output int nbytes);
      logic [7:0]  bytes [$];
      logic [31:0] w;
      logic [31:0] d;
      exp_addr.delete();
      exp_data.delete();
      foreach (frame[i]) begin
         w = frame[i];
         for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < int'(w[h*16 +: 8]); c++) bytes.push_back(w[h*16+8 +: 8]);
         end
      end
      nbytes = bytes.size();
      for (int i = 0; i < nbytes; i += 4) begin
         d = 32'd0;
         for (int k = 0; k < 4; k++) if (i + k < nbytes) d[k*8 +: 8] = bytes[i+k];
         exp_addr.push_back((oa + 32'(i)) & 32'h0000FFFF);
         exp_data.push_back(d);
      end
   endtask

   task automatic run(input string tag, input logic [31:0] ra, input logic [31:0] oa,
                      input bit hiccup, output int cyc);
      int nbytes;
      logic [31:0] held;
      load_frame(ra);
      build_expect(oa, nbytes);
      wl_addr.delete();
      wl_data.delete();
      @(negedge clk);
      rle_addr = ra;
      rle_size = 32'(frame.size() * 4);
      out_addr = oa;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
      cyc = 1;
      while (done !== 1'b1 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (hiccup && cyc == 5) begin
            start = 1'b1;
            rle_addr = 32'h0000_0800;
            rle_size = 32'd64;
            out_addr = 32'h0000_9000;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_out_size"}, out_size, 32'(nbytes));
      check({tag, "_nwrites"}, 32'(wl_addr.size()), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < wl_addr.size(); i++) begin
         check($sformatf("%s_waddr%0d", tag, i), wl_addr[i], exp_addr[i]);
         check($sformatf("%s_wdata%0d", tag, i), wl_data[i], exp_data[i]);
      end
      held = out_size;
      repeat (4) @(negedge clk);
      check({tag, "_done_hold"}, {31'd0, done}, 32'd1);
      check({tag, "_size_hold"}, out_size, held);
      check({tag, "_no_late_wr"}, 32'(wl_addr.size()), 32'(exp_addr.size()));
   endtask

   initial begin
      int cyc;
      int nw;
      logic [31:0] w;
      for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
      nreset = 1'b0;
      start = 1'b0;
      rle_addr = 32'd0;
      rle_size = 32'd0;
      out_addr = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_out_size", out_size, 32'd0);
      check("rst_we", {31'd0, port_A_we}, 32'd0);
      check("rst_addr", {16'd0, port_A_addr}, 32'd0);
      check("rst_data_in", port_A_data_in, 32'd0);
      nreset = 1'b1;
      @(negedge clk);

      frame = '{32'h0000_4103};
      run("single", 32'h0000_0000, 32'h0000_0100, 1'b0, cyc);

      frame = '{32'h4202_4102, 32'h4404_4301};
      run("two", 32'h0000_0000, 32'h0000_0200, 1'b0, cyc);

      frame = '{32'h0000_5AFF};
      run("max", 32'h0000_0000, 32'h0000_1000, 1'b0, cyc);

      frame = '{32'h0000_5A04};
      run("lane0", 32'h0000_0000, 32'h0000_1400, 1'b0, cyc);

      frame = '{};
      run("empty", 32'h0000_0000, 32'h0000_1800, 1'b0, cyc);
      check("empty_latency", {31'd0, 1'(cyc <= 3)}, 32'd1);

      // Abort mid-expansion, then rerun the same frame from scratch.
      frame = '{32'h4202_4102, 32'h4404_4301};
      load_frame(32'h0000_0000);
      wl_addr.delete();
      wl_data.delete();
      @(negedge clk);
      rle_addr = 32'd0;
      rle_size = 32'd8;
      out_addr = 32'h0000_0200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      nreset = 1'b0;
      #1;
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_we", {31'd0, port_A_we}, 32'd0);
      repeat (3) @(negedge clk);
      check("abort_no_wr", 32'(wl_addr.size()), 32'd0);
      nreset = 1'b1;
      run("restart", 32'h0000_0000, 32'h0000_0200, 1'b0, cyc);

      run("hiccup", 32'h0000_0000, 32'h0000_0300, 1'b1, cyc);

      frame = '{32'h0000_4103};
      run("again", 32'h0000_0000, 32'h0000_0100, 1'b0, cyc);

      frame = '{32'h4202_4102, 32'h4404_4301};
      run("wrap", 32'h0000_0100, 32'h0000_FFF8, 1'b0, cyc);

      for (int r = 0; r < 8; r++) begin
         frame.delete();
         nw = $urandom_range(1, 4);
         for (int i = 0; i < nw; i++) begin
            w = $urandom();
            w[7:0] = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 9));
            w[23:16] = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 9));
            frame.push_back(w);
         end
         run($sformatf("rand%0d", r), {20'd0, 10'($urandom_range(0, 1000)), 2'b00},
             32'h0000_8000 + {18'd0, 12'($urandom_range(0, 4000)), 2'b00}, 1'b0, cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
